// File: rtl/corner_adjust.sv
// corner_adjust: manual keystone-corner editor.
// Passes raw corner coordinates through until override is raised, then lets the
// arrow buttons nudge the selected corner with press-edge stepping, hold-to-repeat
// and a fast step after sustained hold. All coordinate updates saturate at the
// screen bounds instead of wrapping.
module corner_adjust #(
    parameter int NPTS          = 4,
    parameter int SELW          = (NPTS > 1) ? $clog2(NPTS) : 1,
    parameter int XW            = 10,
    parameter int YW            = 9,
    parameter int SCR_WIDTH     = 639,
    parameter int SCR_HEIGHT    = 479,
    parameter int STEP_SLOW     = 1,
    parameter int STEP_FAST     = 8,
    parameter int REPEAT_DELAY  = 2_000_000,
    parameter int REPEAT_PERIOD = 500_000,
    parameter int FAST_AFTER    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 override,
    input  logic [SELW-1:0]      sel,
    input  logic [NPTS*XW-1:0]   x_raw,
    input  logic [NPTS*YW-1:0]   y_raw,
    output logic [NPTS*XW-1:0]   x,
    output logic [NPTS*YW-1:0]   y,
    output logic [XW-1:0]        display_x,
    output logic [YW-1:0]        display_y,
    output logic                 editing
);

    localparam int IDXW    = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int REPW    = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;

    localparam logic [CNTW-1:0] DELAY_LAST  = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] PERIOD_LAST = CNTW'(REPEAT_PERIOD - 1);
    localparam logic [REPW-1:0] REP_SAT     = REPW'(FAST_AFTER);

    localparam logic [XW:0] X_SLOW = (XW + 1)'(STEP_SLOW);
    localparam logic [XW:0] X_FAST = (XW + 1)'(STEP_FAST);
    localparam logic [YW:0] Y_SLOW = (YW + 1)'(STEP_SLOW);
    localparam logic [YW:0] Y_FAST = (YW + 1)'(STEP_FAST);
    localparam logic [XW:0] X_LIM  = (XW + 1)'(SCR_WIDTH);
    localparam logic [YW:0] Y_LIM  = (YW + 1)'(SCR_HEIGHT);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_EDIT,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_DOWN,
        DIR_UP,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t            state;
    state_t            next_state;
    dir_t              dir;
    dir_t              prev_dir;
    logic [SELW-1:0]   prev_sel;
    logic [CNTW-1:0]   hold_cnt;
    logic [REPW-1:0]   rep_cnt;

    logic [XW-1:0]     xs [NPTS];
    logic [YW-1:0]     ys [NPTS];

    logic              sel_valid;
    logic [IDXW-1:0]   idx;
    logic              new_press;

    logic              load_raw;
    logic              step_en;
    logic              step_fast;
    logic              hold_clr;
    logic              hold_inc;
    logic              rep_clr;
    logic              rep_inc;

    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic [XW:0]       step_x;
    logic [YW:0]       step_y;
    logic [XW:0]       sum_x;
    logic [YW:0]       sum_y;
    logic [XW:0]       diff_x;
    logic [YW:0]       diff_y;
    logic [XW-1:0]     new_x;
    logic [YW-1:0]     new_y;

    // An out-of-range sel selects nothing; idx is forced to 0 so array reads stay in range.
    assign sel_valid = (32'(sel) < 32'(NPTS));
    assign idx       = sel_valid ? IDXW'(sel) : '0;

    // Resolve the pressed buttons to a single active direction, down having highest priority.
    always_comb begin
        dir = DIR_NONE;
        if (down) begin
            dir = DIR_DOWN;
        end else if (up) begin
            dir = DIR_UP;
        end else if (left) begin
            dir = DIR_LEFT;
        end else if (right) begin
            dir = DIR_RIGHT;
        end
    end

    assign new_press = (dir != DIR_NONE) && ((dir != prev_dir) || (sel != prev_sel));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PASS;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping override returns to PASS from anywhere.
    always_comb begin
        next_state = state;
        case (state)
            ST_PASS:   if (override) next_state = ST_EDIT;
            ST_EDIT:   if (new_press) next_state = ST_HOLD;
            ST_HOLD: begin
                if (new_press) begin
                    next_state = ST_HOLD;
                end else if (dir == DIR_NONE) begin
                    next_state = ST_EDIT;
                end else if (hold_cnt == DELAY_LAST) begin
                    next_state = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (new_press) begin
                    next_state = ST_HOLD;
                end else if (dir == DIR_NONE) begin
                    next_state = ST_EDIT;
                end
            end
            default:   next_state = ST_PASS;
        endcase
        if (!override) begin
            next_state = ST_PASS;
        end
    end

    // Per-state controls: raw loading, when to step, step size and counter actions.
    always_comb begin
        load_raw  = 1'b0;
        step_en   = 1'b0;
        step_fast = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        rep_clr   = 1'b0;
        rep_inc   = 1'b0;
        editing   = (state != ST_PASS);
        if (!override || (state == ST_PASS)) begin
            load_raw = 1'b1;
            hold_clr = 1'b1;
            rep_clr  = 1'b1;
        end else if (new_press) begin
            step_en  = 1'b1;
            hold_clr = 1'b1;
            rep_clr  = 1'b1;
        end else if ((state == ST_EDIT) || (dir == DIR_NONE)) begin
            hold_clr = 1'b1;
            rep_clr  = 1'b1;
        end else if (((state == ST_HOLD) && (hold_cnt == DELAY_LAST)) ||
                     ((state == ST_REPEAT) && (hold_cnt == PERIOD_LAST))) begin
            step_en   = 1'b1;
            step_fast = (rep_cnt == REP_SAT);
            hold_clr  = 1'b1;
            rep_inc   = 1'b1;
        end else begin
            hold_inc = 1'b1;
        end
    end

    // Hold/period timer and the saturating count of auto-repeat steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (rep_clr) begin
                rep_cnt <= '0;
            end else if (rep_inc && (rep_cnt != REP_SAT)) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    // Remember last cycle's direction and selection for press-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dir <= DIR_NONE;
            prev_sel <= '0;
        end else begin
            prev_dir <= dir;
            prev_sel <= sel;
        end
    end

    // Saturating step of the selected corner; sums are one bit wider to catch overflow.
    always_comb begin
        cur_x  = xs[idx];
        cur_y  = ys[idx];
        step_x = step_fast ? X_FAST : X_SLOW;
        step_y = step_fast ? Y_FAST : Y_SLOW;
        sum_x  = {1'b0, cur_x} + step_x;
        sum_y  = {1'b0, cur_y} + step_y;
        diff_x = {1'b0, cur_x} - step_x;
        diff_y = {1'b0, cur_y} - step_y;
        new_x  = cur_x;
        new_y  = cur_y;
        case (dir)
            DIR_DOWN:  new_y = (sum_y > Y_LIM) ? Y_LIM[YW-1:0] : sum_y[YW-1:0];
            DIR_UP:    new_y = ({1'b0, cur_y} >= step_y) ? diff_y[YW-1:0] : '0;
            DIR_RIGHT: new_x = (sum_x > X_LIM) ? X_LIM[XW-1:0] : sum_x[XW-1:0];
            DIR_LEFT:  new_x = ({1'b0, cur_x} >= step_x) ? diff_x[XW-1:0] : '0;
            default: begin
                new_x = cur_x;
                new_y = cur_y;
            end
        endcase
    end

    // Corner registers: track raw outside editing, otherwise update only the selected corner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPTS; k++) begin
                xs[k] <= '0;
                ys[k] <= '0;
            end
        end else if (load_raw) begin
            for (int k = 0; k < NPTS; k++) begin
                xs[k] <= x_raw[k*XW +: XW];
                ys[k] <= y_raw[k*YW +: YW];
            end
        end else if (step_en && sel_valid) begin
            xs[idx] <= new_x;
            ys[idx] <= new_y;
        end
    end

    // Display copy of the selected corner, one cycle behind the corner outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_x <= '0;
            display_y <= '0;
        end else begin
            display_x <= sel_valid ? xs[idx] : '0;
            display_y <= sel_valid ? ys[idx] : '0;
        end
    end

    for (genvar g = 0; g < NPTS; g++) begin : g_pack
        assign x[g*XW +: XW] = xs[g];
        assign y[g*YW +: YW] = ys[g];
    end

endmodule

// File: tb/tb_corner_adjust.sv
// Testbench for corner_adjust: directed vectors with a scoreboard queue that a
// negedge monitor drains and compares against the DUT outputs.
module tb_corner_adjust;

    localparam int NPTS = 4;
    localparam int SELW = 3;
    localparam int XW   = 10;
    localparam int YW   = 9;

    localparam int K_X    = 0;
    localparam int K_Y    = 1;
    localparam int K_DX   = 2;
    localparam int K_DY   = 3;
    localparam int K_EDIT = 4;

    typedef struct {
        string name;
        int    kind;
        int    idx;
        int    value;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 up, down, left, right;
    logic                 override;
    logic [SELW-1:0]      sel;
    logic [NPTS*XW-1:0]   x_raw;
    logic [NPTS*YW-1:0]   y_raw;
    logic [NPTS*XW-1:0]   x;
    logic [NPTS*YW-1:0]   y;
    logic [XW-1:0]        display_x;
    logic [YW-1:0]        display_y;
    logic                 editing;

    exp_t sbq[$];
    exp_t cur;
    int   act;
    int   tests_run  = 0;
    int   fail_count = 0;

    int press_y   [12] = '{11, 11, 11, 11, 12, 12, 13, 13, 21, 21, 29, 29};
    int press_dy  [12] = '{10, 11, 11, 11, 11, 12, 12, 13, 13, 21, 21, 29};
    int clamp_x   [12] = '{637, 637, 637, 637, 638, 638, 639, 639, 639, 639, 639, 639};
    int clamp_y   [10] = '{2, 2, 2, 2, 1, 1, 0, 0, 0, 0};
    int prio_y    [17] = '{30, 30, 30, 30, 31, 31, 32, 32, 40, 40, 39, 39, 39, 39, 38, 38, 37};

    corner_adjust #(
        .NPTS(NPTS), .SELW(SELW), .XW(XW), .YW(YW),
        .SCR_WIDTH(639), .SCR_HEIGHT(479),
        .STEP_SLOW(1), .STEP_FAST(8),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .FAST_AFTER(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .override(override), .sel(sel),
        .x_raw(x_raw), .y_raw(y_raw),
        .x(x), .y(y),
        .display_x(display_x), .display_y(display_y),
        .editing(editing)
    );

    always #5 clk = ~clk;

    function automatic int actual_of(int kind, int idx);
        case (kind)
            K_X:     return int'(x[idx*XW +: XW]);
            K_Y:     return int'(y[idx*YW +: YW]);
            K_DX:    return int'(display_x);
            K_DY:    return int'(display_y);
            default: return int'(editing);
        endcase
    endfunction

    // Monitor: drain every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            act = actual_of(cur.kind, cur.idx);
            tests_run++;
            if (act != cur.value) begin
                fail_count++;
                $display("[TB] FAIL %s: got %0d, expected %0d", cur.name, act, cur.value);
            end
        end
    end

    task automatic applyStimulus(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(string name, int kind, int idx, int value);
        sbq.push_back('{name, kind, idx, value});
    endtask

    task automatic set_raw(int k, int xv, int yv);
        x_raw[k*XW +: XW] = XW'(xv);
        y_raw[k*YW +: YW] = YW'(yv);
    endtask

    initial begin
        rst_n = 1'b0; up = 0; down = 0; left = 0; right = 0;
        override = 0; sel = '0; x_raw = '0; y_raw = '0;
        set_raw(0, 50, 10);
        set_raw(1, 100, 20);
        set_raw(2, 636, 30);
        set_raw(3, 40, 3);

        checkOutput("reset_x0", K_X, 0, 0);
        checkOutput("reset_y3", K_Y, 3, 0);
        checkOutput("reset_dx", K_DX, 0, 0);
        checkOutput("reset_edit", K_EDIT, 0, 0);
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(1);
        checkOutput("pass_x1", K_X, 1, 100);
        checkOutput("pass_y3", K_Y, 3, 3);
        checkOutput("pass_edit", K_EDIT, 0, 0);
        applyStimulus(1);
        checkOutput("pass_dx", K_DX, 0, 50);

        // entry capture
        override = 1; sel = 3'd1;
        applyStimulus(1);
        set_raw(1, 200, 20);
        checkOutput("entry_edit", K_EDIT, 0, 1);
        checkOutput("entry_x1", K_X, 1, 100);
        applyStimulus(1);
        checkOutput("entry_hold_x1", K_X, 1, 100);
        checkOutput("entry_dx", K_DX, 0, 100);

        // press / repeat timing
        sel = 3'd0; down = 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("press_y0_%0d", i), K_Y, 0, press_y[i]);
            checkOutput($sformatf("press_dy_%0d", i), K_DY, 0, press_dy[i]);
        end
        down = 0;
        applyStimulus(1);
        checkOutput("release_y0", K_Y, 0, 29);
        checkOutput("release_edit", K_EDIT, 0, 1);
        checkOutput("other_y1", K_Y, 1, 20);

        // clamp right
        sel = 3'd2; right = 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("clamp_x2_%0d", i), K_X, 2, clamp_x[i]);
        end
        right = 0;
        applyStimulus(1);
        checkOutput("clamp_x2_final", K_X, 2, 639);

        // clamp up
        sel = 3'd3; up = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("clamp_y3_%0d", i), K_Y, 3, clamp_y[i]);
        end
        up = 0;
        applyStimulus(1);
        checkOutput("clamp_y3_final", K_Y, 3, 0);
        checkOutput("clamp_x3_kept", K_X, 3, 40);

        // priority and new press on release of the higher-priority button
        sel = 3'd0; down = 1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("prio_y0_%0d", i), K_Y, 0, prio_y[i]);
            if (i == 1) up = 1;
            if (i == 9) down = 0;
        end
        up = 0;
        applyStimulus(1);
        checkOutput("prio_y0_final", K_Y, 0, 37);

        // override drop and recapture
        override = 0;
        applyStimulus(1);
        checkOutput("drop_x0", K_X, 0, 50);
        checkOutput("drop_y0", K_Y, 0, 10);
        checkOutput("drop_x1", K_X, 1, 200);
        checkOutput("drop_x2", K_X, 2, 636);
        checkOutput("drop_y3", K_Y, 3, 3);
        checkOutput("drop_edit", K_EDIT, 0, 0);
        set_raw(0, 77, 10);
        override = 1;
        applyStimulus(1);
        checkOutput("recap_x0", K_X, 0, 77);
        checkOutput("recap_edit", K_EDIT, 0, 1);

        // async reset in REPEAT
        down = 1;
        applyStimulus(5);
        checkOutput("pre_rst_y0", K_Y, 0, 12);
        applyStimulus(1);
        rst_n = 0; down = 0;
        checkOutput("arst_x0", K_X, 0, 0);
        checkOutput("arst_y0", K_Y, 0, 0);
        checkOutput("arst_x1", K_X, 1, 0);
        checkOutput("arst_dx", K_DX, 0, 0);
        checkOutput("arst_dy", K_DY, 0, 0);
        checkOutput("arst_edit", K_EDIT, 0, 0);
        applyStimulus(1);
        rst_n = 1;
        checkOutput("post_rst_y0", K_Y, 0, 0);
        checkOutput("post_rst_x2", K_X, 2, 0);
        checkOutput("post_rst_edit", K_EDIT, 0, 0);
        applyStimulus(1);
        checkOutput("reentry_y0", K_Y, 0, 10);
        checkOutput("reentry_x0", K_X, 0, 77);
        checkOutput("reentry_edit", K_EDIT, 0, 1);

        // out-of-range select
        sel = 3'd5; right = 1;
        applyStimulus(1);
        checkOutput("sel5_x0", K_X, 0, 77);
        checkOutput("sel5_x2", K_X, 2, 636);
        checkOutput("sel5_x3", K_X, 3, 40);
        checkOutput("sel5_edit", K_EDIT, 0, 1);
        applyStimulus(1);
        checkOutput("sel5_dx", K_DX, 0, 0);
        checkOutput("sel5_dy", K_DY, 0, 0);
        applyStimulus(4);
        checkOutput("sel5_late_x0", K_X, 0, 77);
        checkOutput("sel5_late_x1", K_X, 1, 200);
        checkOutput("sel5_late_y2", K_Y, 2, 30);
        right = 0;

        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() > 0) begin
            fail_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/corner_adjust.md
# corner_adjust

Parametrised manual keystone-corner editor for the projector-correction path. It generalises the fixed four-corner arrow-key UI to NPTS corners with configurable coordinate widths and screen bounds. It adds press-edge stepping, hold-to-auto-repeat with a fast step after sustained hold, and saturating clamps. It sits between the accelerometer-LUT corner outputs and the warp engine; its display outputs feed the hex display.

## Interface

- NPTS, 4, number of corners; SELW = clog2(NPTS), minimum 1
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- SCR_WIDTH, 639, maximum legal x
- SCR_HEIGHT, 479, maximum legal y
- STEP_SLOW, 1, step size before fast mode
- STEP_FAST, 8, step size in fast mode
- REPEAT_DELAY, 2_000_000, cycles from press-edge step to first repeat step
- REPEAT_PERIOD, 500_000, cycles between repeat steps
- FAST_AFTER, 8, number of slow repeat steps before switching to STEP_FAST

Ports:

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- up, down, left, right  in  1 each  debounced buttons, level, active-high
- override  in  1  manual-edit enable
- sel  in  SELW  selected corner index; values ≥ NPTS select nothing
- x_raw  in  NPTS*XW  packed raw x; corner k occupies [k*XW +: XW]
- y_raw  in  NPTS*YW  packed raw y
- x  out  NPTS*XW  adjusted x, registered
- y  out  NPTS*YW  adjusted y, registered
- display_x  out  XW  x of corner sel, registered
- display_y  out  YW  y of corner sel, registered
- editing  out  1  high in EDIT/HOLD/REPEAT states

## Operation

- States:
  - PASS: x/y follow raw every cycle.
  - EDIT: override active, no button held.
  - HOLD: button held, waiting REPEAT_DELAY.
  - REPEAT: auto-repeating.
- PASS → EDIT when override = 1. x/y are loaded from raw on that same edge; no step is applied on the entry cycle even if a button is held.
- Active direction: the highest-priority pressed button, priority down > up > left > right; "none" if no button is pressed.
- New press: active direction differs from its value last cycle, or sel changed, while the active direction is not "none".
  - Apply one STEP_SLOW step to corner sel.
  - Clear the hold counter and repeat counter.
  - Go to HOLD.
- HOLD: when the counter reaches REPEAT_DELAY, apply a step, clear the counter, go to REPEAT.
- REPEAT: each REPEAT_PERIOD cycles apply a step and increment the repeat counter, which saturates at FAST_AFTER. The step size is STEP_FAST once the counter equals FAST_AFTER, otherwise STEP_SLOW.
- Active direction "none" in HOLD/REPEAT → EDIT; counters are cleared.
- override = 0 in any state → PASS; x/y resume raw tracking on that edge and manual edits are discarded.
- Step arithmetic (saturating, no wrap):
  - down: y = min(y + s, SCR_HEIGHT)
  - up: y = (y ≥ s) ? y − s : 0
  - right: x = min(x + s, SCR_WIDTH)
  - left: x = (x ≥ s) ? x − s : 0
  - Intermediate sums are computed one bit wider than the coordinate.
- Only corner sel changes; all other corners hold. If sel ≥ NPTS, no step is applied, but the state machine still runs.
- display_x/y register corner sel of the current x/y outputs. They read 0 if sel ≥ NPTS.

## Timing

- Reset (async, rst_n = 0): x, y, display_x, display_y, editing = 0; state = PASS; counters = 0; previous-direction and previous-sel registers = none / 0.
- Raw → x/y latency in PASS: 1 cycle.
- Press-edge step: the new x/y value is visible after the clock edge on which the new active direction is first sampled.
- Repeat steps land exactly REPEAT_DELAY cycles after the press step, then every REPEAT_PERIOD cycles.
- display_* lag x/y by 1 cycle.
- Changing direction or sel mid-hold counts as a new press: immediate slow step, full delay restarts, fast mode is lost.
- Reset asserted mid-hold: everything is cleared immediately. After release, state is PASS with x/y = 0 until the first edge.

## Test plan

Bench parameters: REPEAT_DELAY=4, REPEAT_PERIOD=2, FAST_AFTER=2, STEP_FAST=8.

- Entry capture: override=0 with x_raw corner1 = 100. Raise override, then change x_raw to 200 → corner1 x stays 100. editing=1 one cycle after override rises.
- Press/repeat timing: sel=0, y0 = 10. Hold down from t0 for 12 cycles → y0 = 11 at t0, 12 at t0+4, 13 at t0+6, then 21 at t0+8, 29 at t0+10.
- Clamp: x2 = 636, sel=2, right held to fast mode → x2 saturates at 639 and never wraps. y3 = 3 with up held → 0.
- Priority/new press: down held, then up also asserted → no new press, down continues. Release down while up is held → immediate up step, repeat counter reset.
- Override drop: after edits, deassert override → all x/y equal raw next cycle, editing = 0. Reassert → recapture from raw.
- Async reset mid-REPEAT: pull rst_n low between edges → all outputs 0 immediately, state PASS. sel = 5 with NPTS=4 → no corner changes, display = 0.
